// File: rtl/pcieifc_fifo_arb_pkg.sv
// Shared types for the pcieifc async FIFO write-port arbiter.
package pcieifc_fifo_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XFER  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CLR   = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

  // Free space is ADDR_WIDTH+FREE_PAD_W bits: one bit for the wrap pointer, one so
  // FIFO_DEPTH itself is representable when comparing against len+1.
  localparam int FREE_PAD_W = 2;

endpackage

// File: rtl/pcieifc_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, cyclically.
module pcieifc_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan farthest offset first so the nearest eligible candidate is the last to overwrite.
  always_comb begin
    onehot = '0;
    idx    = '0;
    sum    = '0;
    cand   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (eligible[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/pcieifc_async_fifo_wr_arb.sv
// Write-domain arbiter for one async FIFO write port: packet-atomic round-robin grants
// gated on whole-packet free space, plus a drain-then-clear flush sequence.
module pcieifc_async_fifo_wr_arb
  import pcieifc_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              beat_ack,
  input  logic                            flush_req,
  output logic                            flush_done,
  output logic                            busy,
  input  logic                            wfull,
  input  logic                            wempty,
  input  logic [ADDR_WIDTH:0]             wptr_bin,
  input  logic [ADDR_WIDTH:0]             ptr_bin_r2w,
  output logic                            winc,
  output logic [DATA_WIDTH-1:0]           wdata,
  output logic                            wclr
);

  localparam int PTR_W  = ADDR_WIDTH + 1;
  localparam int FREE_W = ADDR_WIDTH + FREE_PAD_W;
  localparam int IDX_W  = $clog2(NUM_REQ);

  arb_state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]         gnt_q, gnt_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [LEN_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       busy_q, busy_d;
  logic                       wclr_q, wclr_d;
  logic                       flush_done_q, flush_done_d;

  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  len_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;
  logic [NUM_REQ-1:0]         elig, pick_oh;
  logic [IDX_W-1:0]           pick_idx;
  logic [PTR_W-1:0]           used;
  logic [FREE_W-1:0]          free;

  assign len_a  = req_len;
  assign data_a = req_data;

  // r2w lags the real read pointer, so this never overstates free space.
  assign used = wptr_bin - ptr_bin_r2w;
  assign free = FREE_W'(FIFO_DEPTH) - {1'b0, used};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign elig[i] = req_valid[i] && (free >= FREE_W'(len_a[i]) + FREE_W'(1));
  end

  pcieifc_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .eligible (elig),
    .rr_ptr   (rr_ptr_q),
    .onehot   (pick_oh),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      wclr_q       <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      wclr_q       <= wclr_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_DRAIN;
        end else if (|elig) begin
          state_d  = ST_XFER;
          gnt_d    = pick_oh;
          cnt_d    = len_a[pick_idx];
          rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      ST_XFER: begin
        if (winc) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: if (wempty) state_d = ST_CLR;
      ST_CLR:   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d       = (state_d != ST_IDLE);
    wclr_d       = (state_d == ST_CLR);
    flush_done_d = (state_d == ST_DONE);
  end

  always_comb begin
    winc     = (state_q == ST_XFER) && !wfull;
    beat_ack = gnt_q & {NUM_REQ{winc}};
    wdata    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) wdata = wdata | data_a[i];
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign wclr       = wclr_q;
  assign flush_done = flush_done_q;

endmodule
